// File: rtl/aes128_pkg.sv
// ============================================================================
// Package  : aes128_pkg
// Brief    : Shared AES-128 constants, S-box lookup, round-constant lookup,
//            GF(2^8) doubling helper and the sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes128_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // S-box, entry 0 in the top byte, entry 255 in the bottom byte
  localparam logic [2047:0] c_sbox_table = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits (255 - x) bytes above the LSB, i.e. at bit offset {~x, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return 8'(c_sbox_table >> {~x, 3'b000});
  endfunction

  // Round constant for rounds 1..10; zero outside that range
  function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
    logic [7:0] v;
    v = 8'h00;
    case (round)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_key_step.sv
// ============================================================================
// Module   : aes128_key_step
// Brief    : Combinational AES-128 key-schedule step: derives the next round
//            key from the current one and the round constant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_key_step
  import aes128_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = rk[127:96];
  assign w_w1 = rk[95:64];
  assign w_w2 = rk[63:32];
  assign w_w3 = rk[31:0];

  // RotWord then SubWord on the last word, round constant into the top byte
  assign w_temp = {sbox(w_w3[23:16]) ^ rcon,
                   sbox(w_w3[15:8]),
                   sbox(w_w3[7:0]),
                   sbox(w_w3[31:24])};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign rk_next = {w_n0, w_n1, w_n2, w_n3};

endmodule

`default_nettype wire

// File: rtl/mix_columns.sv
// ============================================================================
// Module   : mix_columns
// Brief    : Combinational MixColumns stage, fixed {02,03,01,01} matrix per
//            column.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_columns
  import aes128_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_state[127-32*gc -: 8];
    assign w_a1 = i_state[119-32*gc -: 8];
    assign w_a2 = i_state[111-32*gc -: 8];
    assign w_a3 = i_state[103-32*gc -: 8];
    assign o_state[127-32*gc -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[119-32*gc -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[111-32*gc -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_state[103-32*gc -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

`default_nettype wire

// File: rtl/shift_rows.sv
// ============================================================================
// Module   : shift_rows
// Brief    : Combinational ShiftRows stage; row r rotates left by r columns.
//            Byte index is row + 4*column, byte 0 at [127:120].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rows (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      assign o_state[127-8*(gr+4*gc) -: 8] = i_state[127-8*(gr+4*((gc+gr)%4)) -: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sub_bytes.sv
// ============================================================================
// Module   : sub_bytes
// Brief    : Combinational SubBytes stage, S-box applied to all 16 bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub_bytes
  import aes128_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar gb = 0; gb < 16; gb++) begin : g_byte
    assign o_state[127-8*gb -: 8] = sbox(i_state[127-8*gb -: 8]);
  end

endmodule

`default_nettype wire

// File: rtl/aes128_iter_ctrl.sv
// ============================================================================
// Module   : aes128_iter_ctrl
// Brief    : Iterative AES-128 encryption sequencer, one round per clock with
//            on-the-fly key expansion. Optional sink backpressure on the
//            ciphertext output is enabled by defining AES_OUT_BACKPRESSURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_iter_ctrl
  import aes128_pkg::*;
#(
  parameter int NR = aes128_pkg::NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
`ifdef AES_OUT_BACKPRESSURE_EN
  input  logic         out_ready,
`endif
  output logic [127:0] ct_out,
  output logic         busy,
  output logic [3:0]   round_o
);

  localparam logic [3:0] c_last_round = 4'(NR);

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [127:0] r_ct;
  logic [3:0]   r_round;
  logic         r_out_valid;
  logic         r_busy;

  logic [127:0] w_sb, w_sr, w_mc;
  logic [127:0] w_rk_next;
  logic [127:0] w_round_out;
  logic         w_last;
  logic         w_release;

  assign w_last = (r_round == c_last_round);

`ifdef AES_OUT_BACKPRESSURE_EN
  assign w_release = out_ready;
`else
  assign w_release = 1'b1;
`endif

  sub_bytes   u_sub_bytes   (.i_state(r_state), .o_state(w_sb));
  shift_rows  u_shift_rows  (.i_state(w_sb),    .o_state(w_sr));
  mix_columns u_mix_columns (.i_state(w_sr),    .o_state(w_mc));

  aes128_key_step u_key_step (
    .rk      (r_rk),
    .rcon    (rcon_lookup(r_round)),
    .rk_next (w_rk_next)
  );

  // The final round skips MixColumns
  assign w_round_out = (w_last ? w_sr : w_mc) ^ w_rk_next;

  // Gated by the reset pin so the producer sees not-ready while held in reset
  assign in_ready  = reset && (r_fsm == ST_IDLE);
  assign out_valid = r_out_valid;
  assign ct_out    = r_ct;
  assign busy      = r_busy;
  assign round_o   = r_round;

  // Sequencer: accept a block, run the rounds, present the ciphertext
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_rk        <= '0;
      r_ct        <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid) begin
            r_state <= pt_in ^ key_in;
            r_rk    <= key_in;
            r_round <= 4'd1;
            r_busy  <= 1'b1;
            r_fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_state <= w_round_out;
          r_rk    <= w_rk_next;
          if (w_last) begin
            r_ct        <= w_round_out;
            r_out_valid <= 1'b1;
            r_round     <= 4'd0;
            r_fsm       <= ST_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_fsm       <= ST_IDLE;
          end
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aes128_iter_ctrl.sv
// ============================================================================
// Module   : tb_aes128_iter_ctrl
// Brief    : Self-checking bench for aes128_iter_ctrl: known-answer vectors,
//            random blocks against a byte-array AES model, handshake, reset
//            and (with AES_OUT_BACKPRESSURE_EN) output backpressure sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes128_iter_ctrl;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_in;
  logic [127:0] key_in;
  logic         out_valid;
`ifdef AES_OUT_BACKPRESSURE_EN
  logic         out_ready;
`endif
  logic [127:0] ct_out;
  logic         busy;
  logic [3:0]   round_o;

  int total = 0;
  int bad   = 0;

  aes128_iter_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
`ifdef AES_OUT_BACKPRESSURE_EN
    .out_ready (out_ready),
`endif
    .ct_out    (ct_out),
    .busy      (busy),
    .round_o   (round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full block from IDLE: accept, watch rounds, check result and release
  task automatic do_block(input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp, input string tag);
    int k;
    check1({tag, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; pt_in = pt; key_in = key;
    step();
    in_valid = 1'b0;
    check1({tag, "_busy_run"}, busy, 1'b1);
    check1({tag, "_in_ready_run"}, in_ready, 1'b0);
    check_int({tag, "_round_after_accept"}, int'(round_o), 1);
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      pt_in = rnd128(); key_in = rnd128();
      step();
      k++;
      if (out_valid !== 1'b1 && k < 10) check_int({tag, "_round_step"}, int'(round_o), k + 1);
    end
    check1({tag, "_out_valid_seen"}, out_valid, 1'b1);
    check_int({tag, "_latency"}, k, 10);
    check128({tag, "_ct"}, ct_out, exp);
    check_int({tag, "_round_done"}, int'(round_o), 0);
    check1({tag, "_in_ready_done"}, in_ready, 1'b0);
    step();
    check1({tag, "_out_valid_pulse"}, out_valid, 1'b0);
    check1({tag, "_in_ready_back"}, in_ready, 1'b1);
    check1({tag, "_busy_idle"}, busy, 1'b0);
    check128({tag, "_ct_hold"}, ct_out, exp);
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  initial begin
    logic [127:0] pa, ka, pb, kb, ea, eb;
    int k;

    vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{pt: 128'h0, key: 128'h0,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    reset = 1'b0; in_valid = 1'b0; pt_in = '0; key_in = '0;
`ifdef AES_OUT_BACKPRESSURE_EN
    out_ready = 1'b1;
`endif
    build_sbox();

    // reset values while held low
    repeat (3) @(negedge clk);
    check1("rst_in_ready_low", in_ready, 1'b0);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check_int("rst_round", int'(round_o), 0);
    check128("rst_ct", ct_out, 128'h0);
    reset = 1'b1;
    #1;
    check1("rst_in_ready_released", in_ready, 1'b1);
    @(negedge clk);

    // known-answer vectors
    for (int i = 0; i < 3; i++) begin
      check128("model_vs_vector", aes_ref(vecs[i].pt, vecs[i].key), vecs[i].ct);
      do_block(vecs[i].pt, vecs[i].key, vecs[i].ct, $sformatf("kat%0d", i));
    end

    // random blocks against the model
    for (int i = 0; i < 6; i++) begin
      pa = rnd128(); ka = rnd128();
      do_block(pa, ka, aes_ref(pa, ka), $sformatf("rnd%0d", i));
    end

    // in_valid held high throughout with changing data
    pa = rnd128(); ka = rnd128(); pb = rnd128(); kb = rnd128();
    ea = aes_ref(pa, ka); eb = aes_ref(pb, kb);
    in_valid = 1'b1; pt_in = pa; key_in = ka;
    step();
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      pt_in = rnd128(); key_in = rnd128();
      step();
      k++;
    end
    check_int("hold_first_latency", k, 10);
    check128("hold_first_ct", ct_out, ea);
    pt_in = pb; key_in = kb;
    step();
    check1("hold_in_ready_back", in_ready, 1'b1);
    check1("hold_idle_busy", busy, 1'b0);
    step();
    in_valid = 1'b0;
    check1("hold_second_busy", busy, 1'b1);
    check_int("hold_second_round", int'(round_o), 1);
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check_int("hold_second_latency", k, 10);
    check128("hold_second_ct", ct_out, eb);
    step();

    // reset asserted at round 5
    in_valid = 1'b1; pt_in = rnd128(); key_in = rnd128();
    step();
    in_valid = 1'b0;
    k = 0;
    while (round_o != 4'd5 && k < 20) begin
      step();
      k++;
    end
    check_int("mid_reset_reach_round5", int'(round_o), 5);
    reset = 1'b0;
    #1;
    check1("mid_reset_in_ready", in_ready, 1'b0);
    check1("mid_reset_out_valid", out_valid, 1'b0);
    check1("mid_reset_busy", busy, 1'b0);
    check_int("mid_reset_round", int'(round_o), 0);
    check128("mid_reset_ct", ct_out, 128'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      check1("mid_reset_no_out_valid", out_valid, 1'b0);
    end
    reset = 1'b1;
    #1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check1("post_reset_no_out_valid", out_valid, 1'b0);
      if (i < 11) step();
    end
    pa = rnd128(); ka = rnd128();
    do_block(pa, ka, aes_ref(pa, ka), "post_reset");

`ifdef AES_OUT_BACKPRESSURE_EN
    // sink stalls for 7 cycles in DONE
    pa = rnd128(); ka = rnd128(); ea = aes_ref(pa, ka);
    out_ready = 1'b0;
    in_valid = 1'b1; pt_in = pa; key_in = ka;
    step();
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check_int("bp_latency", k, 10);
    for (int i = 0; i < 7; i++) begin
      check1("bp_out_valid_held", out_valid, 1'b1);
      check128("bp_ct_held", ct_out, ea);
      check1("bp_in_ready_low", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    check1("bp_out_valid_before_release", out_valid, 1'b1);
    step();
    check1("bp_out_valid_released", out_valid, 1'b0);
    check1("bp_in_ready_released", in_ready, 1'b1);
    check128("bp_ct_after", ct_out, ea);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes128_iter_ctrl.md
# aes128_iter_ctrl

Iterative AES-128 encryption sequencer. It accepts one plaintext block and one cipher key through a valid/ready handshake, then runs the ten rounds one per clock. Each round passes the state through the team's combinational sub_bytes, shift_rows and mix_columns stages, and the round keys are expanded on the fly. It sits between the host-facing register/stream interface and the combinational round datapath, and owns the state register, round counter and key register.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128, present for package consistency only
Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; all registers clear while low
- in_valid  input  1  plaintext/key presented
- in_ready  output  1  high only in IDLE
- pt_in  input  128  plaintext; byte 0 at [127:120], column-major
- key_in  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext valid
- out_ready  input  1  sink accepts ciphertext (only with AES_OUT_BACKPRESSURE_EN)
- ct_out  output  128  ciphertext; stable while out_valid high
- busy  output  1  high in RUN or DONE
- round_o  output  4  current round number, 0 in IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: state <= pt_in ^ key_in, rk <= key_in, round <= 1, go to RUN.
- RUN, round r in 1..10:
  - rk_n = key_step(rk, RCON[r]).
  - Rounds 1..9: state <= mix_columns(shift_rows(sub_bytes(state))) ^ rk_n.
  - Round 10: mix_columns is bypassed.
  - rk <= rk_n; round <= r+1.
  - After round 10, go to DONE and load ct_out <= the new state.
- DONE: out_valid=1.
  - Without the macro: one cycle, then IDLE.
  - With the macro: hold until out_ready, then IDLE.
- pt_in and key_in are sampled only at acceptance; changes during RUN/DONE are ignored.
- in_valid during RUN/DONE is not accepted (in_ready=0). The producer holds it.
- All XORs are 128-bit and byte-aligned. The round counter is 4 bits and never exceeds 11.
- Reset low at any time, including mid-RUN: FSM to IDLE, the current block is discarded, no out_valid is produced.

## Timing
- Reset values: in_ready=1 after reset release (0 while reset is low), out_valid=0, busy=0, round_o=0, ct_out=0.
- Accepting edge is E0. Rounds execute on edges E1..E10. out_valid is high in the cycle after E10.
- Latency is 10 cycles from accept to out_valid.
- Without the macro, in_ready rises in the cycle after DONE. Throughput is one block per 12 cycles.
- ct_out holds its value after out_valid falls, until the next block's E10.
- round_o shows the round about to execute on the next edge: 1 after E0, 10 after E9, 0 in IDLE/DONE.

## Configuration
- AES_OUT_BACKPRESSURE_EN:
  - Defined: out_ready port exists. DONE persists until out_ready=1, and out_valid/ct_out are held stable meanwhile. out_ready high together with out_valid returns the FSM to IDLE on that edge.
  - Undefined: no out_ready port. out_valid is a single-cycle pulse and the sink must capture it.

## Structure
- Package aes128_pkg:
  - NR
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36
  - S-box lookup function
  - FSM state enum (2-bit: IDLE=0, RUN=1, DONE=2)
- Sub-module aes128_key_step: combinational, inputs rk[127:0] and rcon[7:0], output next round key. It computes RotWord/SubWord on the last word, XORs rcon into the MSB, and chains the XOR across words 0..3.
- Round datapath stages are instantiated as existing combinational modules. The controller contains no S-box logic of its own beyond the key step.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct_out 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. round_o steps 1..10 then 0.
- in_valid held high continuously with changing pt_in during RUN -> only the first block is processed. The second is accepted the cycle in_ready returns, and both ciphertexts are correct.
- Reset pulled low at round 5 -> out_valid never asserts, all outputs at reset values. The next block after release yields a correct ciphertext.
- With AES_OUT_BACKPRESSURE_EN: out_ready low for 7 cycles after DONE -> out_valid and ct_out stable for all 7, IDLE entered on the edge out_ready=1.
- Without the macro: out_valid is a one-cycle pulse. in_ready is low from E0 through DONE and high the cycle after.
